// File: rtl/var_delay_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package   : var_delay_pkg                                            |
// | Purpose   : Default parameters and width helpers for var_delay_line  |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
package var_delay_pkg;

    localparam int c_def_width       = 1;
    localparam int c_def_max_len     = 15;
    localparam int c_def_clock_hz    = 12_000_000;
    localparam int c_def_debounce_ms = 10;
    localparam int c_def_wrap        = 1;

    function automatic int calc_len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    function automatic int calc_db_cnt(input int clock_hz, input int debounce_ms);
        return (clock_hz / 1000) * debounce_ms;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : btn_debounce                                             |
// | Purpose   : Synchronise and debounce a button, emit a press pulse    |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module btn_debounce #(
    parameter int DB_CNT = 4
) (
    input  logic ext_clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int                 c_cnt_w  = $clog2(DB_CNT + 1);
    localparam logic [c_cnt_w-1:0] c_reload = c_cnt_w'(DB_CNT);
    localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_state;
    logic               r_state_d;
    logic               r_press;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_dec;
    logic               w_mis;

    // An idle counter (0) loads DB_CNT on a fresh mismatch; losing the mismatch aborts.
    assign w_mis     = r_sync2 ^ r_state;
    assign w_cnt_dec = (r_cnt == '0) ? c_reload : r_cnt - c_one;

    always_ff @(posedge ext_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_state   <= 1'b0;
            r_state_d <= 1'b0;
            r_press   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= btn;
            r_sync2   <= r_sync1;
            r_state_d <= r_state;
            r_press   <= r_state & ~r_state_d;
            if (w_mis) begin
                if (w_cnt_dec == c_one) begin
                    r_state <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt   <= w_cnt_dec;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/var_delay_line.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : var_delay_line                                           |
// | Purpose   : Button-adjustable delay line counted in valid samples    |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module var_delay_line
    import var_delay_pkg::*;
#(
    parameter int  WIDTH       = c_def_width,
    parameter int  MAX_LEN     = c_def_max_len,
    parameter int  CLOCK_HZ    = c_def_clock_hz,
    parameter int  DEBOUNCE_MS = c_def_debounce_ms,
    parameter int  WRAP        = c_def_wrap,
    localparam int LEN_W       = calc_len_w(MAX_LEN)
) (
    input  logic             ext_clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             btn_up,
    input  logic             btn_down,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic [LEN_W-1:0] len,
    output logic             out_en
);

    localparam int               DB_CNT    = calc_db_cnt(CLOCK_HZ, DEBOUNCE_MS);
    localparam logic [LEN_W-1:0] c_max     = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] c_len_one = LEN_W'(1);

    logic             w_up_p;
    logic             w_down_p;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] w_len_nxt;
    logic [LEN_W-1:0] r_fill;
    logic [WIDTH-1:0] r_line [MAX_LEN];
    logic [WIDTH-1:0] w_tap;

    btn_debounce #(.DB_CNT(DB_CNT)) u_db_up (
        .ext_clk (ext_clk),
        .rst_n   (rst_n),
        .btn     (btn_up),
        .press   (w_up_p)
    );

    btn_debounce #(.DB_CNT(DB_CNT)) u_db_down (
        .ext_clk (ext_clk),
        .rst_n   (rst_n),
        .btn     (btn_down),
        .press   (w_down_p)
    );

    // Simultaneous up and down pulses cancel.
    always_comb begin
        w_len_nxt = r_len;
        if (w_up_p && !w_down_p) begin
            if (r_len >= c_max) begin
                w_len_nxt = (WRAP != 0) ? '0 : c_max;
            end else begin
                w_len_nxt = r_len + c_len_one;
            end
        end else if (w_down_p && !w_up_p) begin
            if (r_len == '0) begin
                w_len_nxt = (WRAP != 0) ? c_max : '0;
            end else begin
                w_len_nxt = r_len - c_len_one;
            end
        end
    end

    always_ff @(posedge ext_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len  <= '0;
            r_fill <= '0;
        end else begin
            r_len <= w_len_nxt;
            if (in_valid && (r_fill != c_max)) begin
                r_fill <= r_fill + c_len_one;
            end
        end
    end

    always_ff @(posedge ext_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < MAX_LEN; k++) begin
                r_line[k] <= '0;
            end
        end else if (in_valid) begin
            r_line[0] <= in_data;
            for (int k = 1; k < MAX_LEN; k++) begin
                r_line[k] <= r_line[k-1];
            end
        end
    end

    always_comb begin
        w_tap = '0;
        for (int k = 1; k <= MAX_LEN; k++) begin
            if (r_len == LEN_W'(k)) begin
                w_tap = r_line[k-1];
            end
        end
    end

    // Length zero is a combinational bypass; otherwise validity waits for the line to fill.
    assign out_data  = (r_len == '0) ? in_data  : w_tap;
    assign out_valid = (r_len == '0) ? in_valid : (in_valid && (r_fill >= r_len));
    assign len       = r_len;
    assign out_en    = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_var_delay_line.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tb_var_delay_line                                        |
// | Purpose   : Randomised self-checking bench, wrapping and saturating  |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module tb_var_delay_line;

    localparam int c_max = 15;
    localparam int c_db  = 4;

    logic       ext_clk  = 1'b0;
    logic       rst_n    = 1'b0;
    logic [7:0] in_data  = '0;
    logic       in_valid = 1'b0;
    logic       btn_up   = 1'b0;
    logic       btn_down = 1'b0;

    logic [7:0] out_data_w, out_data_s;
    logic       out_valid_w, out_valid_s;
    logic [3:0] len_w, len_s;
    logic       out_en_w, out_en_s;

    int         n_checks = 0;
    int         n_errors = 0;
    logic       chk_en   = 1'b0;
    int         m_len_w  = 0;
    int         m_len_s  = 0;
    logic [7:0] hist[$];
    logic [7:0] seq      = '0;

    always #5 ext_clk = ~ext_clk;

    var_delay_line #(.WIDTH(8), .MAX_LEN(c_max), .CLOCK_HZ(1000), .DEBOUNCE_MS(4), .WRAP(1)) dut_w (
        .ext_clk(ext_clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .btn_up(btn_up), .btn_down(btn_down), .out_data(out_data_w), .out_valid(out_valid_w),
        .len(len_w), .out_en(out_en_w)
    );

    var_delay_line #(.WIDTH(8), .MAX_LEN(c_max), .CLOCK_HZ(1000), .DEBOUNCE_MS(4), .WRAP(0)) dut_s (
        .ext_clk(ext_clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .btn_up(btn_up), .btn_down(btn_down), .out_data(out_data_s), .out_valid(out_valid_s),
        .len(len_s), .out_en(out_en_s)
    );

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int upd(input int l, input int dir, input bit wrap);
        if (dir > 0) return (l == c_max) ? (wrap ? 0 : c_max) : l + 1;
        if (dir < 0) return (l == 0) ? (wrap ? c_max : 0) : l - 1;
        return l;
    endfunction

    // Compare both instances against the sample history, one clock per call.
    task automatic step(input logic v, input logic [7:0] d);
        in_valid = v;
        in_data  = d;
        #1;
        if (chk_en) begin
            chk_val("valid_w", out_valid_w, (m_len_w == 0) ? v : (v && hist.size() >= m_len_w));
            chk_val("valid_s", out_valid_s, (m_len_s == 0) ? v : (v && hist.size() >= m_len_s));
            if (m_len_w == 0) chk_val("data_w", out_data_w, d);
            else if (hist.size() >= m_len_w) chk_val("data_w", out_data_w, hist[hist.size() - m_len_w]);
            if (m_len_s == 0) chk_val("data_s", out_data_s, d);
            else if (hist.size() >= m_len_s) chk_val("data_s", out_data_s, hist[hist.size() - m_len_s]);
        end
        @(posedge ext_clk);
        if (v && rst_n) begin
            hist.push_back(d);
            if (hist.size() > c_max) void'(hist.pop_front());
        end
        @(negedge ext_clk);
    endtask

    task automatic run(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            if (mode == 0) begin
                step(1'b1, seq);
                seq++;
            end else if (mode == 1) begin
                step((i % 2) == 0, seq);
                seq++;
            end else begin
                step(1'($urandom_range(0, 1)), 8'($urandom));
            end
        end
    endtask

    task automatic buttons(input logic up, input logic dn, input bit feed);
        btn_up   = up;
        btn_down = dn;
        repeat (c_db + 8) step(feed ? 1'($urandom_range(0, 1)) : 1'b0, 8'($urandom));
        btn_up   = 1'b0;
        btn_down = 1'b0;
        repeat (c_db + 8) step(feed ? 1'($urandom_range(0, 1)) : 1'b0, 8'($urandom));
    endtask

    task automatic press(input int dir, input bit feed);
        logic save;
        save   = chk_en;
        chk_en = 1'b0;
        if (dir > 0) buttons(1'b1, 1'b0, feed);
        else if (dir < 0) buttons(1'b0, 1'b1, feed);
        else buttons(1'b1, 1'b1, feed);
        m_len_w = upd(m_len_w, dir, 1'b1);
        m_len_s = upd(m_len_s, dir, 1'b0);
        chk_val("len_w", len_w, m_len_w);
        chk_val("len_s", len_s, m_len_s);
        chk_en = save;
    endtask

    // Drop reset mid-cycle and confirm outputs clear without waiting for a clock.
    task automatic do_reset();
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        #1;
        rst_n = 1'b0;
        hist.delete();
        m_len_w = 0;
        m_len_s = 0;
        #1;
        chk_val("rst_len_w", len_w, 0);
        chk_val("rst_len_s", len_s, 0);
        chk_val("rst_vld_w", out_valid_w, 1);
        chk_val("rst_dat_w", out_data_w, in_data);
        chk_val("rst_dat_s", out_data_s, in_data);
        chk_val("rst_en_w", out_en_w, 1);
        chk_val("rst_en_s", out_en_s, 1);
        in_valid = 1'b0;
        repeat (2) @(negedge ext_clk);
        rst_n = 1'b1;
    endtask

    initial begin
        @(negedge ext_clk);
        do_reset();

        // Pass-through at length zero.
        chk_en = 1'b1;
        run(20, 0);

        // Three presses with no samples accepted, then delayed streams.
        chk_en = 1'b0;
        do_reset();
        repeat (3) press(1, 1'b0);
        chk_en = 1'b1;
        run(10, 0);
        run(20, 1);
        run(30, 2);

        // Short glitches must not count; the stable press that follows must.
        chk_en = 1'b0;
        repeat (3) begin
            btn_up = 1'b1;
            repeat (2) step(1'b1, 8'($urandom));
            btn_up = 1'b0;
            repeat (3) step(1'b1, 8'($urandom));
        end
        repeat (c_db + 6) step(1'b1, 8'($urandom));
        chk_val("glitch_w", len_w, m_len_w);
        chk_val("glitch_s", len_s, m_len_s);
        press(1, 1'b1);
        chk_en = 1'b1;
        run(20, 2);

        // Wrap versus saturate at both ends.
        chk_en = 1'b0;
        do_reset();
        repeat (16) press(1, 1'b1);
        chk_en = 1'b1;
        run(30, 2);
        chk_en = 1'b0;
        repeat (16) press(-1, 1'b1);
        chk_en = 1'b1;
        run(20, 2);

        // Coincident presses cancel; then down from zero.
        chk_en = 1'b0;
        press(0, 1'b1);
        press(-1, 1'b1);
        chk_en = 1'b1;
        run(40, 2);

        // Reset mid-stream at len 7 with a full line.
        chk_en = 1'b0;
        do_reset();
        repeat (7) press(1, 1'b0);
        chk_en = 1'b1;
        run(20, 0);
        do_reset();
        run(5, 0);
        chk_en = 1'b0;
        do_reset();
        repeat (3) press(1, 1'b0);
        chk_en = 1'b1;
        run(10, 0);
        run(10, 2);
        chk_en = 1'b0;

        // Reset during the debounce count discards the pending press.
        btn_up = 1'b1;
        repeat (4) step(1'b0, 8'h00);
        rst_n  = 1'b0;
        btn_up = 1'b0;
        hist.delete();
        m_len_w = 0;
        m_len_s = 0;
        repeat (2) @(negedge ext_clk);
        rst_n = 1'b1;
        repeat (c_db + 10) step(1'b0, 8'h00);
        chk_val("abort_w", len_w, 0);
        chk_val("abort_s", len_s, 0);

        // Button held through reset release: pulse after DB_CNT+3 clocks, len one later.
        rst_n  = 1'b0;
        btn_up = 1'b1;
        repeat (3) @(negedge ext_clk);
        rst_n = 1'b1;
        repeat (c_db + 3) step(1'b0, 8'h00);
        chk_val("held_early", len_w, 0);
        step(1'b0, 8'h00);
        m_len_w = upd(m_len_w, 1, 1'b1);
        m_len_s = upd(m_len_s, 1, 1'b0);
        chk_val("held_w", len_w, m_len_w);
        chk_val("held_s", len_s, m_len_s);
        btn_up = 1'b0;
        repeat (c_db + 8) step(1'b0, 8'h00);
        chk_val("held_once", len_w, m_len_w);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
